// File: rtl/pnr_pkg.sv
// ============================================================================
// Module : pnr_pkg
// Brief  : Shared FSM state encodings and helpers for the PNR window classifier
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pnr_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OPEN = 2'd1;
    localparam logic [1:0] ST_CMP  = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    function automatic int pn_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Sign-extend the low w bits of v to 32 bits (sample widths up to 32).
    function automatic logic [31:0] sext(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = v;
        for (int i = 0; i < 32; i++) begin
            if (i >= w) r[i] = v[w-1];
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pnr_thermo_count.sv
// ============================================================================
// Module : pnr_thermo_count
// Brief  : Registered peak-vs-threshold compare vector and its popcount
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pnr_thermo_count
    import pnr_pkg::*;
#(
    parameter int ADC_W = 14,
    parameter int N_THR = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic signed [ADC_W:0]        peak,
    input  logic [N_THR*ADC_W-1:0]       thr,
    output logic [$clog2(N_THR+1)-1:0]   count
);

    localparam int PN_W = pn_width(N_THR);

    logic [N_THR-1:0] ge_d, ge_q;
    logic signed [ADC_W:0] thr_x;

    always_comb begin
        ge_d  = ge_q;
        thr_x = '0;
        if (en) begin
            for (int i = 0; i < N_THR; i++) begin
                thr_x    = $signed((ADC_W+1)'(sext(32'(thr[i*ADC_W +: ADC_W]), ADC_W)));
                ge_d[i]  = (peak >= thr_x);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ge_q <= '0;
        else     ge_q <= ge_d;
    end

    // Counting exceeded thresholds keeps the class defined for any threshold ordering.
    always_comb begin
        count = '0;
        for (int i = 0; i < N_THR; i++) begin
            count = count + PN_W'(ge_q[i]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/pnr_window_classifier.sv
// ============================================================================
// Module : pnr_window_classifier
// Brief  : Triggered peak-hold window, photon-number classifier and histogram
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pnr_window_classifier
    import pnr_pkg::*;
#(
    parameter int ADC_W   = 14,
    parameter int N_THR   = 8,
    parameter int MAX_WIN = 256,
    parameter int HIST_W  = 32
) (
    input  logic                          ADC_CLK,
    input  logic                          rst_i,
    input  logic                          trigger,
    input  logic                          delayed_trigger,
    input  logic [ADC_W-1:0]              pnr_source_sig,
    input  logic [N_THR*ADC_W-1:0]        adc_photon_threshold,
    input  logic                          baseline_en,
    input  logic                          hist_clear,
    input  logic [$clog2(N_THR+1)-1:0]    hist_rd_idx,
    output logic [HIST_W-1:0]             hist_rd_data,
    output logic [$clog2(N_THR+1)-1:0]    photon_num,
    output logic                          photon_valid,
    output logic [ADC_W:0]                peak_value,
    output logic                          timeout_flag,
    output logic                          overlap_err,
    output logic                          busy
);

    localparam int PN_W  = pn_width(N_THR);
    localparam int PW    = ADC_W + 1;
    localparam int CNT_W = $clog2(MAX_WIN + 1);

    logic [1:0]               state_d, state_q;
    logic signed [PW-1:0]     baseline_d, baseline_q;
    logic signed [PW-1:0]     peak_d, peak_q;
    logic [CNT_W-1:0]         cnt_d, cnt_q;
    logic [N_THR*ADC_W-1:0]   thr_d, thr_q;
    logic                     tmo_pend_d, tmo_pend_q;
    logic [PN_W-1:0]          photon_num_d, photon_num_q;
    logic                     photon_valid_d, photon_valid_q;
    logic [PW-1:0]            peak_value_d, peak_value_q;
    logic                     timeout_flag_d, timeout_flag_q;
    logic                     overlap_err_d, overlap_err_q;
    logic [HIST_W-1:0]        hist_d [0:N_THR];
    logic [HIST_W-1:0]        hist_q [0:N_THR];
    logic [HIST_W-1:0]        rd_d, rd_q;

    logic signed [PW-1:0]     sample_x;
    logic signed [PW-1:0]     diff;
    logic [PN_W-1:0]          pop;

    assign sample_x = $signed(PW'(sext(32'(pnr_source_sig), ADC_W)));
    assign diff     = sample_x - baseline_q;

    pnr_thermo_count #(
        .ADC_W (ADC_W),
        .N_THR (N_THR)
    ) u_thermo (
        .clk   (ADC_CLK),
        .rst   (rst_i),
        .en    (state_q == ST_CMP),
        .peak  (peak_q),
        .thr   (thr_q),
        .count (pop)
    );

    always_comb begin
        state_d        = state_q;
        baseline_d     = baseline_q;
        peak_d         = peak_q;
        cnt_d          = cnt_q;
        thr_d          = thr_q;
        tmo_pend_d     = tmo_pend_q;
        photon_num_d   = photon_num_q;
        photon_valid_d = 1'b0;
        peak_value_d   = peak_value_q;
        timeout_flag_d = timeout_flag_q;
        overlap_err_d  = overlap_err_q;
        hist_d         = hist_q;

        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d    = ST_OPEN;
                    baseline_d = baseline_en ? sample_x : '0;
                    thr_d      = adc_photon_threshold;
                    peak_d     = {1'b1, {ADC_W{1'b0}}};
                    cnt_d      = '0;
                end
            end
            ST_OPEN: begin
                if (diff > peak_q) peak_d = diff;
                cnt_d = cnt_q + CNT_W'(1);
                if (delayed_trigger || (cnt_q == CNT_W'(MAX_WIN - 1))) begin
                    state_d    = ST_CMP;
                    tmo_pend_d = !delayed_trigger;
                end
            end
            ST_CMP: begin
                state_d = ST_OUT;
            end
            default: begin
                state_d        = ST_IDLE;
                photon_valid_d = 1'b1;
                photon_num_d   = pop;
                peak_value_d   = peak_q;
                timeout_flag_d = tmo_pend_q;
                if (hist_q[pop] != {HIST_W{1'b1}}) hist_d[pop] = hist_q[pop] + HIST_W'(1);
            end
        endcase

        if (trigger && (state_q != ST_IDLE)) overlap_err_d = 1'b1;

        // Clear takes priority over a same-cycle increment and overlap report.
        if (hist_clear) begin
            overlap_err_d = 1'b0;
            for (int i = 0; i <= N_THR; i++) hist_d[i] = '0;
        end

        rd_d = (hist_rd_idx <= PN_W'(N_THR)) ? hist_q[hist_rd_idx] : '0;
    end

    always_ff @(posedge ADC_CLK or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            baseline_q     <= '0;
            peak_q         <= '0;
            cnt_q          <= '0;
            thr_q          <= '0;
            tmo_pend_q     <= 1'b0;
            photon_num_q   <= '0;
            photon_valid_q <= 1'b0;
            peak_value_q   <= '0;
            timeout_flag_q <= 1'b0;
            overlap_err_q  <= 1'b0;
            rd_q           <= '0;
            for (int i = 0; i <= N_THR; i++) hist_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            baseline_q     <= baseline_d;
            peak_q         <= peak_d;
            cnt_q          <= cnt_d;
            thr_q          <= thr_d;
            tmo_pend_q     <= tmo_pend_d;
            photon_num_q   <= photon_num_d;
            photon_valid_q <= photon_valid_d;
            peak_value_q   <= peak_value_d;
            timeout_flag_q <= timeout_flag_d;
            overlap_err_q  <= overlap_err_d;
            rd_q           <= rd_d;
            for (int i = 0; i <= N_THR; i++) hist_q[i] <= hist_d[i];
        end
    end

    assign hist_rd_data = rd_q;
    assign photon_num   = photon_num_q;
    assign photon_valid = photon_valid_q;
    assign peak_value   = peak_value_q;
    assign timeout_flag = timeout_flag_q;
    assign overlap_err  = overlap_err_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

`default_nettype wire
